// File: rtl/maxpool_stream_if.sv
// Stream bundle for the max-pool stage: pixel input, pooled output and
// frame control.
//
// Handshake rule for both streams: the producer raises *_vld with stable data
// and holds data and *_vld unchanged until the consumer's *_rdy is high on the
// same rising edge. A transfer happens on exactly those edges. The producer
// never waits for *_rdy before asserting *_vld.
interface maxpool_stream_if #(
  parameter int DATA_W = 18,
  parameter int CH     = 2
);
  logic                 strt;
  logic                 din_vld;
  logic [CH*DATA_W-1:0] din;
  logic                 din_rdy;
  logic                 dout_vld;
  logic [CH*DATA_W-1:0] dout;
  logic                 dout_rdy;
  logic                 bsy;
  logic                 done;

  modport master (
    output strt, din_vld, din, dout_rdy,
    input  din_rdy, dout_vld, dout, bsy, done
  );

  modport slave (
    input  strt, din_vld, din, dout_rdy,
    output din_rdy, dout_vld, dout, bsy, done
  );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming POOL x POOL max-pool over a raster-ordered, multi-channel image.
// One running maximum per window column per channel is kept in a line buffer;
// the pooled word leaves one cycle after the window's last pixel is accepted.
module maxpool_stream #(
  parameter int DATA_W = 18,
  parameter int CH     = 2,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int POOL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  maxpool_stream_if.slave  bus,
  output logic [1:0]       state_dbg
);

  localparam int WIN_N = IMG_W / POOL;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PC_W  = $clog2(POOL);
  localparam int WC_W  = (WIN_N > 1) ? $clog2(WIN_N) : 1;

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || POOL > 4) begin : g_bad_param
    $error("maxpool_stream: IMG_W and IMG_H must be multiples of POOL, POOL must be 2..4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PC_W-1:0]  pc, pr;
  logic [WC_W-1:0]  wc;

  logic signed [DATA_W-1:0] lb      [CH][WIN_N];
  logic signed [DATA_W-1:0] px      [CH];
  logic signed [DATA_W-1:0] lb_cur  [CH];
  logic signed [DATA_W-1:0] run_max [CH];

  logic                 dout_vld_q;
  logic [CH*DATA_W-1:0] dout_q;
  logic                 done_q;

  logic din_rdy, accept, first_px, win_done, col_last, row_last, pc_last, pr_last;
  logic drain_exit;

  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign pc_last  = (pc == PC_W'(POOL - 1));
  assign pr_last  = (pr == PC_W'(POOL - 1));

  // Handshake qualifiers: input stalls only while a pooled word is waiting.
  always_comb begin
    din_rdy    = 1'b0;
    drain_exit = 1'b0;
    if (state == RUN) din_rdy = !(dout_vld_q && !bus.dout_rdy);
    if (state == DRAIN) drain_exit = !dout_vld_q || bus.dout_rdy;
  end

  assign accept   = din_rdy && bus.din_vld;
  assign first_px = (pr == '0) && (pc == '0);
  assign win_done = accept && pr_last && pc_last;

  // Per-channel unpack and signed running max against the window's buffer slot.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      px[c]      = bus.din[c*DATA_W +: DATA_W];
      lb_cur[c]  = lb[c][wc];
      run_max[c] = (px[c] > lb_cur[c]) ? px[c] : lb_cur[c];
    end
  end

  // Line buffer: the first pixel of a window seeds the slot, the rest fold in.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        lb[c][wc] <= first_px ? px[c] : run_max[c];
      end
    end
  end

  // Raster position counters; window column advances without a divider.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && bus.strt)) begin
      col <= '0;
      row <= '0;
      pc  <= '0;
      pr  <= '0;
      wc  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        pc  <= '0;
        wc  <= '0;
        if (row_last) begin
          row <= '0;
          pr  <= '0;
        end else begin
          row <= row + 1'b1;
          pr  <= pr_last ? '0 : pr + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (pc_last) begin
          pc <= '0;
          wc <= wc + 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

  // Output register: loads on window completion, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
    end else if (win_done) begin
      dout_vld_q <= 1'b1;
      for (int c = 0; c < CH; c++) begin
        dout_q[c*DATA_W +: DATA_W] <= run_max[c];
      end
    end else if (dout_vld_q && bus.dout_rdy) begin
      dout_vld_q <= 1'b0;
    end
  end

  // Frame-end pulse, one cycle after the drain condition is met.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= drain_exit;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.strt) state_nxt = RUN;
      RUN:     if (accept && row_last && col_last) state_nxt = DRAIN;
      DRAIN:   if (drain_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.din_rdy  = din_rdy;
  assign bus.dout_vld = dout_vld_q;
  assign bus.dout     = dout_q;
  assign bus.bsy      = (state != IDLE);
  assign bus.done     = done_q;
  assign state_dbg    = state;

endmodule
